// File: rtl/id_ex_stage_pkg.sv
// Shared definitions for the ID/EX pipeline register: ALU control codes,
// operand-forwarding select encodings and the hardwired-zero register index.
package id_ex_stage_pkg;

  localparam logic [3:0] ALU_AND = 4'd0;
  localparam logic [3:0] ALU_OR  = 4'd1;
  localparam logic [3:0] ALU_ADD = 4'd2;
  localparam logic [3:0] ALU_XOR = 4'd3;
  localparam logic [3:0] ALU_NOR = 4'd4;
  localparam logic [3:0] ALU_SUB = 4'd6;
  localparam logic [3:0] ALU_SLT = 4'd7;
  localparam logic [3:0] ALU_SLL = 4'd8;
  localparam logic [3:0] ALU_SRL = 4'd9;
  localparam logic [3:0] ALU_SRA = 4'd10;

  typedef enum logic [1:0] {
    FWD_REG = 2'd0,
    FWD_MEM = 2'd1,
    FWD_WB  = 2'd2
  } fwd_sel_e;

  localparam int unsigned REG_ZERO = 0;

endpackage

// File: rtl/id_ex_stage_if.sv
// Decode-side, bypass-network and ALU-side signals of the ID/EX stage.
// master = environment (decode, MEM/WB, ALU); slave = the stage itself.
interface id_ex_stage_if #(
  parameter int REGW = 5,
  parameter int XLEN = 32
) ();
  logic                        i_valid;
  logic [3:0]                  i_ctl;
  logic [REGW-1:0]             i_rs;
  logic [REGW-1:0]             i_rt;
  logic [XLEN-1:0]             i_rs_val;
  logic [XLEN-1:0]             i_rt_val;
  logic [XLEN-1:0]             i_imm;
  logic                        i_use_imm;
  logic [REGW-1:0]             i_rd;
  logic                        i_wen;
  logic                        i_load;
  logic                        i_hold;
  logic                        i_flush;
  logic                        i_mem_wen;
  logic [REGW-1:0]             i_mem_rd;
  logic [XLEN-1:0]             i_mem_res;
  logic                        i_wb_wen;
  logic [REGW-1:0]             i_wb_rd;
  logic [XLEN-1:0]             i_wb_res;
  logic [XLEN-1:0]             o_op1;
  logic [XLEN-1:0]             o_op2;
  logic [3:0]                  o_ctl;
  logic [REGW-1:0]             o_rd;
  logic                        o_wen;
  logic                        o_load;
  logic                        o_valid;
  logic                        o_stall;
  id_ex_stage_pkg::fwd_sel_e   o_op1_sel;
  id_ex_stage_pkg::fwd_sel_e   o_op2_sel;

  modport master (
    output i_valid, i_ctl, i_rs, i_rt, i_rs_val, i_rt_val, i_imm, i_use_imm,
           i_rd, i_wen, i_load, i_hold, i_flush,
           i_mem_wen, i_mem_rd, i_mem_res, i_wb_wen, i_wb_rd, i_wb_res,
    input  o_op1, o_op2, o_ctl, o_rd, o_wen, o_load, o_valid, o_stall,
           o_op1_sel, o_op2_sel
  );

  modport slave (
    input  i_valid, i_ctl, i_rs, i_rt, i_rs_val, i_rt_val, i_imm, i_use_imm,
           i_rd, i_wen, i_load, i_hold, i_flush,
           i_mem_wen, i_mem_rd, i_mem_res, i_wb_wen, i_wb_rd, i_wb_res,
    output o_op1, o_op2, o_ctl, o_rd, o_wen, o_load, o_valid, o_stall,
           o_op1_sel, o_op2_sel
  );
endinterface

// File: rtl/id_ex_stage_fwd_mux.sv
// Operand bypass for one source register: the EX/MEM result wins over MEM/WB,
// and r0 never forwards so it always reads the stored value.
module fwd_mux
  import id_ex_stage_pkg::*;
#(
  parameter int REGW = 5,
  parameter int XLEN = 32
) (
  input  logic [REGW-1:0] i_idx,
  input  logic [XLEN-1:0] i_reg_val,
  input  logic            i_mem_wen,
  input  logic [REGW-1:0] i_mem_rd,
  input  logic [XLEN-1:0] i_mem_res,
  input  logic            i_wb_wen,
  input  logic [REGW-1:0] i_wb_rd,
  input  logic [XLEN-1:0] i_wb_res,
  output logic [XLEN-1:0] o_val,
  output fwd_sel_e        o_sel
);

  localparam logic [REGW-1:0] ZERO_IDX = REGW'(REG_ZERO);

  always_comb begin
    o_sel = FWD_REG;
    o_val = i_reg_val;
    if (i_idx != ZERO_IDX) begin
      if (i_mem_wen && (i_mem_rd == i_idx)) begin
        o_sel = FWD_MEM;
        o_val = i_mem_res;
      end else if (i_wb_wen && (i_wb_rd == i_idx)) begin
        o_sel = FWD_WB;
        o_val = i_wb_res;
      end
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: latches one decoded instruction per cycle, bypasses
// MEM/WB results onto the ALU operands and inserts a bubble on load-use hazards.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int REGW = 5,
  parameter int XLEN = 32
) (
  input  logic       i_clk,
  input  logic       i_rst,
  id_ex_stage_if.slave bus
);

  localparam logic [REGW-1:0] ZERO_IDX = REGW'(REG_ZERO);

  logic            valid_q,   valid_d;
  logic [3:0]      ctl_q,     ctl_d;
  logic [REGW-1:0] rs_q,      rs_d;
  logic [REGW-1:0] rt_q,      rt_d;
  logic [XLEN-1:0] rs_val_q,  rs_val_d;
  logic [XLEN-1:0] rt_val_q,  rt_val_d;
  logic [XLEN-1:0] imm_q,     imm_d;
  logic            use_imm_q, use_imm_d;
  logic [REGW-1:0] rd_q,      rd_d;
  logic            wen_q,     wen_d;
  logic            load_q,    load_d;

  logic            hazard;
  logic [XLEN-1:0] rs_cap;
  logic [XLEN-1:0] rt_cap;
  logic [XLEN-1:0] rt_fwd;

  always_comb begin
    hazard = valid_q && load_q && wen_q && (rd_q != ZERO_IDX) && bus.i_valid &&
             ((rd_q == bus.i_rs) || ((rd_q == bus.i_rt) && !bus.i_use_imm));

    // A write retiring from MEM/WB this cycle is not yet visible in the
    // register-file read, so take the writeback value directly.
    rs_cap = (bus.i_wb_wen && (bus.i_wb_rd != ZERO_IDX) && (bus.i_wb_rd == bus.i_rs))
             ? bus.i_wb_res : bus.i_rs_val;
    rt_cap = (bus.i_wb_wen && (bus.i_wb_rd != ZERO_IDX) && (bus.i_wb_rd == bus.i_rt))
             ? bus.i_wb_res : bus.i_rt_val;

    valid_d   = valid_q;
    ctl_d     = ctl_q;
    rs_d      = rs_q;
    rt_d      = rt_q;
    rs_val_d  = rs_val_q;
    rt_val_d  = rt_val_q;
    imm_d     = imm_q;
    use_imm_d = use_imm_q;
    rd_d      = rd_q;
    wen_d     = wen_q;
    load_d    = load_q;

    if (bus.i_flush || (!bus.i_hold && hazard)) begin
      valid_d = 1'b0;
      wen_d   = 1'b0;
      load_d  = 1'b0;
    end else if (!bus.i_hold) begin
      valid_d   = bus.i_valid;
      ctl_d     = bus.i_ctl;
      rs_d      = bus.i_rs;
      rt_d      = bus.i_rt;
      rs_val_d  = rs_cap;
      rt_val_d  = rt_cap;
      imm_d     = bus.i_imm;
      use_imm_d = bus.i_use_imm;
      rd_d      = bus.i_rd;
      wen_d     = bus.i_wen && bus.i_valid;
      load_d    = bus.i_load && bus.i_valid;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      valid_q   <= 1'b0;
      ctl_q     <= '0;
      rs_q      <= '0;
      rt_q      <= '0;
      rs_val_q  <= '0;
      rt_val_q  <= '0;
      imm_q     <= '0;
      use_imm_q <= 1'b0;
      rd_q      <= '0;
      wen_q     <= 1'b0;
      load_q    <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      ctl_q     <= ctl_d;
      rs_q      <= rs_d;
      rt_q      <= rt_d;
      rs_val_q  <= rs_val_d;
      rt_val_q  <= rt_val_d;
      imm_q     <= imm_d;
      use_imm_q <= use_imm_d;
      rd_q      <= rd_d;
      wen_q     <= wen_d;
      load_q    <= load_d;
    end
  end

  // ---- ID/EX register boundary: operand forwarding into the ALU ----
  fwd_mux #(.REGW(REGW), .XLEN(XLEN)) u_fwd_op1 (
    .i_idx     (rs_q),
    .i_reg_val (rs_val_q),
    .i_mem_wen (bus.i_mem_wen),
    .i_mem_rd  (bus.i_mem_rd),
    .i_mem_res (bus.i_mem_res),
    .i_wb_wen  (bus.i_wb_wen),
    .i_wb_rd   (bus.i_wb_rd),
    .i_wb_res  (bus.i_wb_res),
    .o_val     (bus.o_op1),
    .o_sel     (bus.o_op1_sel)
  );

  fwd_mux #(.REGW(REGW), .XLEN(XLEN)) u_fwd_op2 (
    .i_idx     (rt_q),
    .i_reg_val (rt_val_q),
    .i_mem_wen (bus.i_mem_wen),
    .i_mem_rd  (bus.i_mem_rd),
    .i_mem_res (bus.i_mem_res),
    .i_wb_wen  (bus.i_wb_wen),
    .i_wb_rd   (bus.i_wb_rd),
    .i_wb_res  (bus.i_wb_res),
    .o_val     (rt_fwd),
    .o_sel     (bus.o_op2_sel)
  );

  assign bus.o_op2   = use_imm_q ? imm_q : rt_fwd;
  assign bus.o_ctl   = ctl_q;
  assign bus.o_rd    = rd_q;
  assign bus.o_wen   = wen_q;
  assign bus.o_load  = load_q;
  assign bus.o_valid = valid_q;
  assign bus.o_stall = bus.i_hold || hazard;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed scenarios plus random traffic, checked by a
// scoreboard fed from a behavioural model of the held instruction.
module tb_id_ex_stage;
  import id_ex_stage_pkg::*;

  localparam int REGW = 5;
  localparam int XLEN = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  id_ex_stage_if #(.REGW(REGW), .XLEN(XLEN)) bus ();

  id_ex_stage #(.REGW(REGW), .XLEN(XLEN)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus.slave)
  );

  typedef struct {
    logic        live, known, wen, load, use_imm;
    logic [3:0]  ctl;
    logic [4:0]  rs, rt, rd;
    logic [31:0] rsv, rtv, imm;
  } slot_t;

  typedef struct {
    logic        stall, valid, wen, load, known;
    logic [3:0]  ctl;
    logic [4:0]  rd;
    logic [31:0] op1, op2;
    logic [1:0]  sel1, sel2;
  } exp_t;

  slot_t m;
  exp_t  q[$];
  int    checks = 0;
  int    errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", nm, act, req);
    end
  endtask

  // Newest in-flight producer of a register: EX/MEM is younger than MEM/WB.
  function automatic fwd_sel_e source_of(input logic [4:0] idx);
    if (idx == 5'd0) return FWD_REG;
    if (bus.i_mem_wen && bus.i_mem_rd == idx) return FWD_MEM;
    if (bus.i_wb_wen && bus.i_wb_rd == idx) return FWD_WB;
    return FWD_REG;
  endfunction

  function automatic logic [31:0] value_of(input logic [4:0] idx, input logic [31:0] stored);
    case (source_of(idx))
      FWD_MEM: return bus.i_mem_res;
      FWD_WB:  return bus.i_wb_res;
      default: return stored;
    endcase
  endfunction

  function automatic logic load_use();
    return m.live && m.load && m.wen && m.rd != 5'd0 && bus.i_valid &&
           (m.rd == bus.i_rs || (m.rd == bus.i_rt && !bus.i_use_imm));
  endfunction

  function automatic exp_t expect_now();
    exp_t e;
    e.stall = bus.i_hold || load_use();
    e.valid = m.live;
    e.wen   = m.wen;
    e.load  = m.load;
    e.known = m.known;
    e.ctl   = m.ctl;
    e.rd    = m.rd;
    e.op1   = value_of(m.rs, m.rsv);
    e.op2   = m.use_imm ? m.imm : value_of(m.rt, m.rtv);
    e.sel1  = source_of(m.rs);
    e.sel2  = source_of(m.rt);
    return e;
  endfunction

  // What the stage holds after the coming clock edge, given today's inputs.
  function automatic void model_edge();
    if (rst) begin
      m = '{default: '0};
      m.known = 1'b1;
    end else if (bus.i_flush) begin
      m.live = 1'b0; m.wen = 1'b0; m.load = 1'b0;
    end else if (bus.i_hold) begin
      // instruction stays put
    end else if (load_use()) begin
      m.live = 1'b0; m.wen = 1'b0; m.load = 1'b0; m.known = 1'b0;
    end else begin
      m.live    = bus.i_valid;
      m.known   = 1'b1;
      m.ctl     = bus.i_ctl;
      m.rs      = bus.i_rs;
      m.rt      = bus.i_rt;
      m.rsv     = (bus.i_wb_wen && bus.i_wb_rd != 0 && bus.i_wb_rd == bus.i_rs) ? bus.i_wb_res : bus.i_rs_val;
      m.rtv     = (bus.i_wb_wen && bus.i_wb_rd != 0 && bus.i_wb_rd == bus.i_rt) ? bus.i_wb_res : bus.i_rt_val;
      m.imm     = bus.i_imm;
      m.use_imm = bus.i_use_imm;
      m.rd      = bus.i_rd;
      m.wen     = bus.i_wen && bus.i_valid;
      m.load    = bus.i_load && bus.i_valid;
    end
  endfunction

  task automatic idle();
    bus.i_valid = 0; bus.i_ctl = 0; bus.i_rs = 0; bus.i_rt = 0;
    bus.i_rs_val = 0; bus.i_rt_val = 0; bus.i_imm = 0; bus.i_use_imm = 0;
    bus.i_rd = 0; bus.i_wen = 0; bus.i_load = 0; bus.i_hold = 0; bus.i_flush = 0;
    bus.i_mem_wen = 0; bus.i_mem_rd = 0; bus.i_mem_res = 0;
    bus.i_wb_wen = 0; bus.i_wb_rd = 0; bus.i_wb_res = 0;
  endtask

  // Inputs are stable from here to the edge; the monitor checks at negedge.
  task automatic cycle();
    #1 q.push_back(expect_now());
    @(posedge clk);
    model_edge();
    #1;
  endtask

  // Scoreboard monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("sb_stall", 32'(bus.o_stall), 32'(e.stall));
        chk("sb_valid", 32'(bus.o_valid), 32'(e.valid));
        chk("sb_wen",   32'(bus.o_wen),   32'(e.wen));
        chk("sb_load",  32'(bus.o_load),  32'(e.load));
        if (e.known) begin
          chk("sb_ctl",  32'(bus.o_ctl), 32'(e.ctl));
          chk("sb_rd",   32'(bus.o_rd),  32'(e.rd));
          chk("sb_op1",  bus.o_op1, e.op1);
          chk("sb_op2",  bus.o_op2, e.op2);
          chk("sb_sel1", 32'(bus.o_op1_sel), 32'(e.sel1));
          chk("sb_sel2", 32'(bus.o_op2_sel), 32'(e.sel2));
        end
      end
    end
  end

  initial begin
    idle();
    rst = 1'b1;
    @(posedge clk);
    model_edge();
    #1 rst = 1'b0;
    #1 chk("reset_valid", 32'(bus.o_valid), 0);
    chk("reset_op1", bus.o_op1, 0);

    // Plain capture
    bus.i_valid = 1; bus.i_ctl = ALU_ADD; bus.i_rs = 1; bus.i_rs_val = 5;
    bus.i_rt = 2; bus.i_rt_val = 7; bus.i_rd = 3; bus.i_wen = 1;
    cycle();
    idle();
    #1 chk("add_op1", bus.o_op1, 32'd5);
    chk("add_op2", bus.o_op2, 32'd7);
    chk("add_ctl", 32'(bus.o_ctl), 32'(ALU_ADD));
    chk("add_valid", 32'(bus.o_valid), 1);

    // MEM over WB priority, then WB, then r0 never forwards
    bus.i_valid = 1; bus.i_rs = 3; bus.i_rs_val = 32'h11;
    cycle();
    idle();
    bus.i_mem_wen = 1; bus.i_mem_rd = 3; bus.i_mem_res = 32'hAA;
    bus.i_wb_wen = 1; bus.i_wb_rd = 3; bus.i_wb_res = 32'hBB;
    #1 chk("fwd_mem", bus.o_op1, 32'hAA);
    bus.i_mem_wen = 0;
    #1 chk("fwd_wb", bus.o_op1, 32'hBB);
    bus.i_valid = 1; bus.i_rs = 0; bus.i_rs_val = 0;
    bus.i_mem_wen = 1; bus.i_mem_rd = 0; bus.i_wb_rd = 0;
    cycle();
    #1 chk("fwd_r0", bus.o_op1, 0);

    // Load-use: one bubble, then capture
    idle();
    bus.i_valid = 1; bus.i_load = 1; bus.i_wen = 1; bus.i_rd = 4;
    cycle();
    idle();
    bus.i_valid = 1; bus.i_rs = 4; bus.i_rd = 5; bus.i_wen = 1;
    #1 chk("lu_stall", 32'(bus.o_stall), 1);
    cycle();
    #1 chk("lu_bubble_valid", 32'(bus.o_valid), 0);
    chk("lu_bubble_wen", 32'(bus.o_wen), 0);
    chk("lu_stall_clear", 32'(bus.o_stall), 0);
    cycle();
    chk("lu_captured", 32'(bus.o_valid), 1);
    idle();
    bus.i_valid = 1; bus.i_load = 1; bus.i_wen = 1; bus.i_rd = 4;
    cycle();
    idle();
    bus.i_valid = 1; bus.i_rs = 5; bus.i_rt = 4; bus.i_use_imm = 1; bus.i_imm = 32'd123;
    #1 chk("lu_imm_nostall", 32'(bus.o_stall), 0);
    cycle();

    // Capture bypass from MEM/WB
    idle();
    bus.i_valid = 1; bus.i_rs = 6; bus.i_rs_val = 1;
    bus.i_wb_wen = 1; bus.i_wb_rd = 6; bus.i_wb_res = 9;
    cycle();
    bus.i_wb_wen = 0;
    #1 chk("cap_bypass", bus.o_op1, 32'd9);

    // Hold for three cycles, then flush overrides hold
    idle();
    bus.i_valid = 1; bus.i_ctl = ALU_SUB; bus.i_rs = 1; bus.i_rs_val = 10;
    bus.i_rt = 2; bus.i_rt_val = 20; bus.i_rd = 7; bus.i_wen = 1;
    cycle();
    bus.i_hold = 1; bus.i_ctl = ALU_ADD; bus.i_rs_val = 99; bus.i_rd = 9;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("hold_ctl", 32'(bus.o_ctl), 32'(ALU_SUB));
      chk("hold_op1", bus.o_op1, 32'd10);
      chk("hold_stall", 32'(bus.o_stall), 1);
    end
    bus.i_flush = 1;
    cycle();
    chk("flush_valid", 32'(bus.o_valid), 0);
    chk("flush_wen", 32'(bus.o_wen), 0);

    // Reset mid-stream
    idle();
    bus.i_valid = 1; bus.i_ctl = ALU_XOR; bus.i_rs = 2; bus.i_rs_val = 32'h1234;
    bus.i_rd = 3; bus.i_wen = 1; bus.i_load = 1;
    cycle();
    rst = 1'b1;
    cycle();
    chk("rst_valid", 32'(bus.o_valid), 0);
    chk("rst_wen", 32'(bus.o_wen), 0);
    chk("rst_load", 32'(bus.o_load), 0);
    chk("rst_ctl", 32'(bus.o_ctl), 0);
    chk("rst_rd", 32'(bus.o_rd), 0);
    chk("rst_op1", bus.o_op1, 0);
    chk("rst_op2", bus.o_op2, 0);
    chk("rst_stall", 32'(bus.o_stall), 0);
    rst = 1'b0;

    // Random traffic on a small register window so hazards are frequent
    for (int n = 0; n < 3000; n++) begin
      rst           = ($urandom_range(99) < 2);
      bus.i_valid   = ($urandom_range(99) < 80);
      bus.i_ctl     = 4'($urandom_range(15));
      bus.i_rs      = 5'($urandom_range(7));
      bus.i_rt      = 5'($urandom_range(7));
      bus.i_rs_val  = $urandom;
      bus.i_rt_val  = $urandom;
      bus.i_imm     = $urandom;
      bus.i_use_imm = ($urandom_range(99) < 30);
      bus.i_rd      = 5'($urandom_range(7));
      bus.i_wen     = ($urandom_range(99) < 80);
      bus.i_load    = ($urandom_range(99) < 35);
      bus.i_hold    = ($urandom_range(99) < 10);
      bus.i_flush   = ($urandom_range(99) < 5);
      bus.i_mem_wen = ($urandom_range(99) < 50);
      bus.i_mem_rd  = 5'($urandom_range(7));
      bus.i_mem_res = $urandom;
      bus.i_wb_wen  = ($urandom_range(99) < 50);
      bus.i_wb_rd   = 5'($urandom_range(7));
      bus.i_wb_res  = $urandom;
      cycle();
    end

    rst = 1'b0;
    idle();
    cycle();
    chk("sb_drained", 32'(q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
